// File: rtl/regfile_8x_wr.sv
// 8-entry register file written through a one-hot select from the 3:8 write decoder.
// Two combinational read ports, optional hardwired-zero entry 7, optional write bypass.
module regfile_8x_wr #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [2:0]       rd_addr_a,
    input  logic [2:0]       rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             sel_err
);

    logic [WIDTH-1:0] regs [8];
    logic             one_hot;
    logic             multi_hot;
    logic [7:0]       wr_en;

    // x & (x-1) clears the lowest set bit; non-zero remainder means two or more bits set.
    assign multi_hot = (wr_sel & (wr_sel - 8'd1)) != 8'd0;
    assign one_hot   = (wr_sel != 8'd0) && !multi_hot;

    always_comb begin
        wr_en = 8'd0;
        for (int i = 0; i < 8; i++) begin
            wr_en[i] = one_hot && wr_sel[i] && !((ZERO_REG != 0) && (i == 7));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (wr_en[i]) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_err <= 1'b0;
        end else if (multi_hot) begin
            sel_err <= 1'b1;
        end
    end

    // wr_en already excludes the zero register and multi-hot selects, so it doubles as the bypass hit.
    always_comb begin
        rd_data_a = regs[rd_addr_a];
        if ((BYPASS != 0) && reset_n && wr_en[rd_addr_a]) begin
            rd_data_a = wr_data;
        end
        if ((ZERO_REG != 0) && (rd_addr_a == 3'd7)) begin
            rd_data_a = '0;
        end
    end

    always_comb begin
        rd_data_b = regs[rd_addr_b];
        if ((BYPASS != 0) && reset_n && wr_en[rd_addr_b]) begin
            rd_data_b = wr_data;
        end
        if ((ZERO_REG != 0) && (rd_addr_b == 3'd7)) begin
            rd_data_b = '0;
        end
    end

endmodule
